// File: rtl/ser_pkg.sv
// Shared types and constants for the framed serial transmitter.
package ser_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/ser_tx_bit_timer.sv
// Bit-rate divider: counts 0..DIV-1 and flags the last clock of each bit slot.
module bit_timer #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == TERM) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial framed transmitter: start, W data bits LSB-first,
// optional parity, stop. Each bit is held for DIV clocks.
module ser_tx
  import ser_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIV    = 16,
  parameter int PARITY = PAR_NONE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid,
  input  logic [W-1:0] data,
  output logic         ready,
  output logic         txd,
  output logic         busy
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] LAST = BW'(W - 1);

  tx_state_t     state_q, state_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [BW-1:0] idx_q, idx_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          tick;

  // Divider is held at zero while idle so the start bit gets a full slot.
  bit_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = START;
        sr_d    = data;
        idx_d   = '0;
        par_d   = (^data) ^ (PARITY == PAR_ODD);
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        sr_d = sr_q >> 1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = (PARITY != PAR_NONE) ? PAR : STOP;
        end else begin
          idx_d = idx_q + BW'(1);
        end
      end
      PAR:  if (tick) state_d = STOP;
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so txd is a clean flop output.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sr_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q != IDLE);
  assign txd   = txd_q;

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx: four configurations side by side, checked every cycle
// against a frame-level model plus literal waveform expectations.
module tb_ser_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] vld = '0;
  logic [3:0] rdy, txd, bsy;
  logic [7:0] dat [4];
  bit         chk_en = 1'b0;
  int         n_pass = 0, n_tot = 0;
  int         cyc = 0;
  int         acc_t[$];

  always #5 clk = ~clk;

  ser_tx #(.W(8), .DIV(4), .PARITY(0)) u0 (.clk(clk), .rst_n(rst_n), .valid(vld[0]),
    .data(dat[0]), .ready(rdy[0]), .txd(txd[0]), .busy(bsy[0]));
  ser_tx #(.W(8), .DIV(4), .PARITY(1)) u1 (.clk(clk), .rst_n(rst_n), .valid(vld[1]),
    .data(dat[1]), .ready(rdy[1]), .txd(txd[1]), .busy(bsy[1]));
  ser_tx #(.W(8), .DIV(4), .PARITY(2)) u2 (.clk(clk), .rst_n(rst_n), .valid(vld[2]),
    .data(dat[2]), .ready(rdy[2]), .txd(txd[2]), .busy(bsy[2]));
  ser_tx #(.W(1), .DIV(2), .PARITY(0)) u3 (.clk(clk), .rst_n(rst_n), .valid(vld[3]),
    .data(dat[3][0:0]), .ready(rdy[3]), .txd(txd[3]), .busy(bsy[3]));

  function automatic int cfg_w(int k);   return (k == 3) ? 1 : 8; endfunction
  function automatic int cfg_div(int k); return (k == 3) ? 2 : 4; endfunction
  function automatic int cfg_par(int k); return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction
  function automatic int flen(int k);
    return (cfg_w(k) + 2 + ((cfg_par(k) != 0) ? 1 : 0)) * cfg_div(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  // Frame model: an accepted word becomes a list of bit slots of DIV clocks each.
  bit         m_act [4];
  int         m_pos [4];
  logic [7:0] m_word[4];

  function automatic logic exp_bit(int k);
    int   slot, w;
    logic [7:0] msk;
    w    = cfg_w(k);
    slot = m_pos[k] / cfg_div(k);
    msk  = 8'((1 << w) - 1);
    if (slot == 0) return 1'b0;
    if (slot <= w) return m_word[k][slot-1];
    if (cfg_par(k) != 0 && slot == w + 1)
      return (^(m_word[k] & msk)) ^ (cfg_par(k) == 2);
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) m_act[k] = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_act[k]) begin
          m_pos[k]++;
          if (m_pos[k] == flen(k)) m_act[k] = 1'b0;
        end else if (vld[k]) begin
          m_act[k]  = 1'b1;
          m_pos[k]  = 0;
          m_word[k] = dat[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("txd%0d", k),   32'(txd[k]), 32'(m_act[k] ? exp_bit(k) : 1'b1));
        chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!m_act[k]));
        chk($sformatf("busy%0d", k),  32'(bsy[k]), 32'(m_act[k]));
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst_n && vld[0] && rdy[0]) acc_t.push_back(cyc);
  end

  logic [3:0] cap [50];
  logic [3:0] rc  [50];

  // Present d to all instances for one accept edge, then record 50 cycles.
  task automatic send_capture(input logic [7:0] d);
    @(posedge clk); #1;
    vld = 4'hF;
    for (int k = 0; k < 4; k++) dat[k] = d;
    @(posedge clk); #1;
    vld = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cap[c] = txd;
      rc[c]  = rdy;
    end
  endtask

  function automatic logic [10:0] slots(int k, int n);
    logic [10:0] s = '0;
    for (int i = 0; i < n; i++) s[i] = cap[i*4+2][k];
    return s;
  endfunction

  initial begin
    logic [5:0] w1;
    int         to;
    for (int k = 0; k < 4; k++) dat[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_txd",   32'(txd), 32'h0F);
    chk("rst_ready", 32'(rdy), 32'h0F);
    chk("rst_busy",  32'(bsy), 32'h00);

    send_capture(8'hA5);
    chk("a5_frame_p0",   32'(slots(0, 10)), 32'h34A);
    chk("a5_frame_even", 32'(slots(1, 11)), 32'h54A);
    chk("a5_frame_odd",  32'(slots(2, 11)), 32'h74A);
    chk("p0_ready_39", 32'(rc[39][0]), 32'h0);
    chk("p0_ready_40", 32'(rc[40][0]), 32'h1);
    chk("par_ready_43", 32'(rc[43][1]), 32'h0);
    chk("par_ready_44", 32'(rc[44][1]), 32'h1);
    for (int c = 0; c < 6; c++) w1[c] = cap[c][3];
    chk("w1_wave", 32'(w1), 32'h3C);
    chk("w1_ready_5", 32'(rc[5][3]), 32'h0);
    chk("w1_ready_6", 32'(rc[6][3]), 32'h1);

    send_capture(8'h07);
    chk("07_par_even", 32'(cap[38][1]), 32'h1);
    chk("07_par_odd",  32'(cap[38][2]), 32'h0);

    // Back-to-back with valid held high on instance 0.
    acc_t.delete();
    @(posedge clk); #1;
    vld[0] = 1'b1; dat[0] = 8'h00;
    to = 0;
    while (acc_t.size() < 1 && to < 100) begin @(posedge clk); #1; to++; end
    dat[0] = 8'hFF;
    while (acc_t.size() < 2 && to < 200) begin @(posedge clk); #1; to++; end
    vld[0] = 1'b0;
    chk("b2b_accepts", 32'(acc_t.size()), 32'd2);
    if (acc_t.size() == 2) chk("b2b_gap", 32'(acc_t[1] - acc_t[0]), 32'd41);
    repeat (45) @(posedge clk);

    // Random valid/data toggling, including while busy.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        vld[k] = ($urandom_range(0, 2) == 0);
        dat[k] = 8'($urandom);
      end
    end
    #0 vld = '0;
    repeat (50) @(posedge clk);

    // Asynchronous reset in the middle of a frame.
    @(posedge clk); #1;
    vld = 4'hF;
    for (int k = 0; k < 4; k++) dat[k] = 8'h5A;
    @(posedge clk); #1;
    vld = '0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_txd",   32'(txd), 32'h0F);
    chk("async_ready", 32'(rdy), 32'h0F);
    chk("async_busy",  32'(bsy), 32'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(txd), 32'h0F);
    end
    send_capture(8'h3C);
    chk("post_rst_frame", 32'(slots(0, 10)), 32'h278);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
